// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle between two core stages: upstream valid/ready/payload
// into the stage, and downstream valid/ready/payload out of it.
interface pipe_skid_stage_if #(
   parameter int unsigned DW = 32
);
   logic          in_valid_i;
   logic          in_ready_o;
   logic [DW-1:0] din;
   logic          out_valid_o;
   logic          out_ready_i;
   logic [DW-1:0] qout;

   // The stage itself.
   modport slave (
      input  in_valid_i,
      output in_ready_o,
      input  din,
      output out_valid_o,
      input  out_ready_i,
      output qout
   );

   // The surroundings: producer on the input side, consumer on the output side.
   modport master (
      output in_valid_i,
      input  in_ready_o,
      output din,
      input  out_valid_o,
      output out_ready_i,
      input  qout
   );
endinterface

// File: rtl/pipe_skid_stage.sv
// Pipeline-stage register with a valid/ready handshake and a two-entry skid
// buffer. in_ready_o depends only on registered occupancy and the hold level,
// so downstream backpressure never reaches upstream combinationally.
// Supports global hold by stage index, synchronous flush and a saturating
// stall counter.
module pipe_skid_stage #(
   parameter int unsigned          DW       = 32,
   parameter logic [DW-1:0]        DEF_VAL  = 32'h00000013,
   parameter int unsigned          HOLD_W   = 3,
   parameter logic [HOLD_W-1:0]    STAGE_ID = 3'd2,
   parameter int unsigned          CNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   pipe_skid_stage_if.slave     bus,
   input  logic [HOLD_W-1:0]    hold_flag_i,
   input  logic                 flush_i,
   output logic [CNT_W-1:0]     stall_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      FULL
   } occ_t;

   occ_t          state;
   logic [DW-1:0] main_q;
   logic [DW-1:0] skid_q;
   logic          hold;
   logic          push;
   logic          pop;
   logic          stall;

   // Handshake decode: hold gates both directions, occupancy gates each side.
   always_comb begin
      hold            = (hold_flag_i >= STAGE_ID);
      bus.in_ready_o  = ~hold & (state != FULL);
      bus.out_valid_o = ~hold & (state != EMPTY);
      bus.qout        = main_q;
      push            = bus.in_valid_i & bus.in_ready_o;
      pop             = bus.out_valid_o & bus.out_ready_i;
      stall           = hold | (state == FULL);
   end

   // Occupancy, storage and stall counter; flush wipes the storage but
   // leaves the counter running.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= EMPTY;
         main_q      <= DEF_VAL;
         skid_q      <= DEF_VAL;
         stall_cnt_o <= '0;
      end else begin
         if (stall && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + CNT_ONE;
         end
         if (flush_i) begin
            state  <= EMPTY;
            main_q <= DEF_VAL;
            skid_q <= DEF_VAL;
         end else begin
            case (state)
               EMPTY: begin
                  if (push) begin
                     state  <= ONE;
                     main_q <= bus.din;
                  end
               end
               ONE: begin
                  if (push && pop) begin
                     main_q <= bus.din;
                  end else if (push) begin
                     state  <= FULL;
                     skid_q <= bus.din;
                  end else if (pop) begin
                     state  <= EMPTY;
                     main_q <= DEF_VAL;
                  end
               end
               FULL: begin
                  if (pop) begin
                     state  <= ONE;
                     main_q <= skid_q;
                     skid_q <= DEF_VAL;
                  end
               end
               default: begin
                  state  <= EMPTY;
                  main_q <= DEF_VAL;
                  skid_q <= DEF_VAL;
               end
            endcase
         end
      end
   end

endmodule
